dbus_responder: RTL and testbench

DBUS_RESPONDER -- requirements
Module: dbus_responder

---
 rtl/dbus_responder_pkg.sv | 29 ++
 rtl/strobe_ram.sv | 37 +++
 rtl/dbus_responder.sv | 120 ++++++++++++
 tb/tb_dbus_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/dbus_responder_pkg.sv
// Shared memory-stage data bus types: request/response structs and the word type.
package dbus_responder_pkg;

  typedef logic [63:0] word_t;

  typedef enum logic [2:0] {
    MSize1 = 3'd0,
    MSize2 = 3'd1,
    MSize4 = 3'd2,
    MSize8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    word_t       data;
    logic [7:0]  strobe;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  localparam int unsigned CntW = 4;

endpackage

// File: rtl/strobe_ram.sv
// 64-bit word storage with a byte-enabled write port and an asynchronous read port.
module strobe_ram
  import dbus_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_be,
  input  word_t         i_wdata,
  input  logic [AW-1:0] i_raddr,
  output word_t         o_rdata
);

  word_t r_mem [DEPTH];
  word_t w_merged;

  always_comb begin
    w_merged = r_mem[i_waddr];
    for (int b = 0; b < 8; b++) begin
      if (i_be[b]) begin
        w_merged[8*b +: 8] = i_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= w_merged;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dbus_responder.sv
// Memory-stage data bus target: latches one request, waits LATENCY cycles, returns the
// pre-write word and commits any strobed bytes. All responses come from flops.
module dbus_responder
  import dbus_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 4096,
  parameter int unsigned LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CntW-1:0] LoadCnt = CntW'(LATENCY - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [AW-1:0]   r_index;
  word_t           r_wdata;
  logic [7:0]      r_strobe;
  logic            r_addr_ok, r_data_ok;
  word_t           r_rdata;

  logic  w_accept, w_resp, w_we;
  word_t w_ram_rdata;
  logic  w_unused;

  // Offset bits, bits above the index and size never influence the access.
  assign w_unused = ^{dreq.addr[63:3+AW], dreq.addr[2:0], dreq.size};

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_accept  = 1'b0;
    w_resp    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (dreq.valid) begin
          w_accept = 1'b1;
          w_cnt_d  = LoadCnt;
          if (LATENCY == 1) begin
            w_state_d = StResp;
          end else begin
            w_state_d = StWait;
          end
        end
      end
      StWait: begin
        if (!dreq.valid) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt - CntW'(1);
          if (r_cnt <= CntW'(1)) begin
            w_state_d = StResp;
          end
        end
      end
      StResp: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
        // A dropped request or a reset at this edge suppresses both response and write.
        w_resp    = dreq.valid & reset;
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  assign w_we = w_resp & (r_strobe != 8'h00);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_index   <= '0;
      r_wdata   <= '0;
      r_strobe  <= '0;
      r_addr_ok <= 1'b0;
      r_data_ok <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_addr_ok <= w_accept;
      r_data_ok <= w_resp;
      r_rdata   <= w_resp ? w_ram_rdata : '0;
      if (w_accept) begin
        r_index  <= dreq.addr[3 +: AW];
        r_wdata  <= dreq.data;
        r_strobe <= dreq.strobe;
      end
    end
  end

  strobe_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .i_clk  (clk),
    .i_we   (w_we),
    .i_waddr(r_index),
    .i_be   (r_strobe),
    .i_wdata(r_wdata),
    .i_raddr(r_index),
    .o_rdata(w_ram_rdata)
  );

  assign dresp = '{addr_ok: r_addr_ok, data_ok: r_data_ok, data: r_rdata};

endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench for dbus_responder: a LATENCY=2 instance and a LATENCY=1 instance.
module tb_dbus_responder;
  import dbus_responder_pkg::*;

  logic       clk;
  logic       reset_a, reset_b;
  dbus_req_t  dreq_a, dreq_b;
  dbus_resp_t dresp_a, dresp_b;

  int n_checks;
  int n_fail;

  dbus_responder #(
    .DEPTH  (4096),
    .LATENCY(2)
  ) u_dut_a (
    .clk  (clk),
    .reset(reset_a),
    .dreq (dreq_a),
    .dresp(dresp_a)
  );

  dbus_responder #(
    .DEPTH  (4096),
    .LATENCY(1)
  ) u_dut_b (
    .clk  (clk),
    .reset(reset_b),
    .dreq (dreq_b),
    .dresp(dresp_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit use_b, input logic valid, input logic [63:0] addr,
                         input word_t data, input logic [7:0] strobe);
    dbus_req_t r;
    r.valid  = valid;
    r.addr   = addr;
    r.size   = MSize8;
    r.data   = data;
    r.strobe = strobe;
    if (use_b) dreq_b = r;
    else dreq_a = r;
  endtask

  // Full handshake; optionally scrambles the request fields after it has been accepted.
  task automatic access(input bit use_b, input logic [63:0] addr, input word_t wdata,
                        input logic [7:0] strobe, input bit scramble,
                        output word_t rdata, output int lat);
    dbus_resp_t rsp;
    int n;
    set_req(use_b, 1'b1, addr, wdata, strobe);
    n = 0;
    do begin
      step();
      n++;
      rsp = use_b ? dresp_b : dresp_a;
    end while (!rsp.addr_ok && n < 20);
    check_eq("addr_ok_seen", 64'(rsp.addr_ok), 64'd1);
    if (scramble) set_req(use_b, 1'b1, ~addr, ~wdata, 8'hFF);
    lat = 0;
    do begin
      step();
      lat++;
      rsp = use_b ? dresp_b : dresp_a;
    end while (!rsp.data_ok && lat < 20);
    check_eq("data_ok_seen", 64'(rsp.data_ok), 64'd1);
    rdata = rsp.data;
    set_req(use_b, 1'b0, 64'd0, 64'd0, 8'h00);
    step();
    rsp = use_b ? dresp_b : dresp_a;
    check_eq("data_ok_single_pulse", 64'(rsp.data_ok), 64'd0);
    check_eq("data_zero_when_idle", rsp.data, 64'd0);
  endtask

  initial begin
    word_t rd;
    int    lat;
    n_checks = 0;
    n_fail   = 0;
    reset_a  = 1'b0;
    reset_b  = 1'b0;
    dreq_a   = '0;
    dreq_b   = '0;

    // Reset state
    step();
    step();
    check_eq("rst_addr_ok", 64'(dresp_a.addr_ok), 64'd0);
    check_eq("rst_data_ok", 64'(dresp_a.data_ok), 64'd0);
    check_eq("rst_data", dresp_a.data, 64'd0);
    reset_a = 1'b1;
    reset_b = 1'b1;
    step();
    check_eq("idle_addr_ok", 64'(dresp_a.addr_ok), 64'd0);

    // Full write then read, latency 2
    access(1'b0, 64'h80, 64'h1122334455667788, 8'hFF, 1'b0, rd, lat);
    check_eq("wr80_latency", 64'(lat), 64'd2);
    access(1'b0, 64'h80, 64'h0, 8'h00, 1'b0, rd, lat);
    check_eq("rd80_latency", 64'(lat), 64'd2);
    check_eq("rd80_data", rd, 64'h1122334455667788);

    // Partial write; write returns pre-write word; offset bits ignored on read
    access(1'b0, 64'h80, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b0, rd, lat);
    check_eq("wr80_prewrite", rd, 64'h1122334455667788);
    access(1'b0, 64'h80, 64'h00000000AABB0000, 8'h0C, 1'b0, rd, lat);
    check_eq("wr80_partial_prewrite", rd, 64'hFFFFFFFFFFFFFFFF);
    access(1'b0, 64'h84, 64'h0, 8'h00, 1'b0, rd, lat);
    check_eq("rd84_merged", rd, 64'hFFFFFFFFAABBFFFF);

    // Aliasing above the index
    access(1'b0, 64'h0, 64'h0123456789ABCDEF, 8'hFF, 1'b0, rd, lat);
    access(1'b0, 64'h8000, 64'h000000000000005A, 8'h01, 1'b0, rd, lat);
    access(1'b0, 64'h0, 64'h0, 8'h00, 1'b0, rd, lat);
    check_eq("alias_rd0", rd, 64'h0123456789ABCD5A);

    // Fields changed after accept are ignored (latched read, no write)
    access(1'b0, 64'h80, 64'h0, 8'h00, 1'b1, rd, lat);
    check_eq("scrambled_rd80", rd, 64'hFFFFFFFFAABBFFFF);
    access(1'b0, 64'h80, 64'h0, 8'h00, 1'b0, rd, lat);
    check_eq("rd80_after_scramble", rd, 64'hFFFFFFFFAABBFFFF);

    // Abort: valid dropped after the WAIT cycle
    access(1'b0, 64'h100, 64'h00000000CAFEF00D, 8'hFF, 1'b0, rd, lat);
    set_req(1'b0, 1'b1, 64'h100, 64'h000000000000DEAD, 8'hFF);
    step();
    check_eq("abort_addr_ok", 64'(dresp_a.addr_ok), 64'd1);
    step();
    set_req(1'b0, 1'b0, 64'd0, 64'd0, 8'h00);
    step();
    check_eq("abort_no_data_ok", 64'(dresp_a.data_ok), 64'd0);
    check_eq("abort_data_zero", dresp_a.data, 64'd0);
    step();
    check_eq("abort_no_data_ok_late", 64'(dresp_a.data_ok), 64'd0);
    access(1'b0, 64'h100, 64'h0, 8'h00, 1'b0, rd, lat);
    check_eq("abort_rd_old", rd, 64'h00000000CAFEF00D);

    // Reset in WAIT of a write, valid held through it
    access(1'b0, 64'h200, 64'h0000000000001111, 8'hFF, 1'b0, rd, lat);
    set_req(1'b0, 1'b1, 64'h200, 64'h0000000000002222, 8'hFF);
    step();
    check_eq("rstop_addr_ok", 64'(dresp_a.addr_ok), 64'd1);
    reset_a = 1'b0;
    step();
    check_eq("rstop_addr_ok_clr", 64'(dresp_a.addr_ok), 64'd0);
    check_eq("rstop_data_ok_clr", 64'(dresp_a.data_ok), 64'd0);
    check_eq("rstop_data_clr", dresp_a.data, 64'd0);
    step();
    check_eq("rstop_data_ok_hold", 64'(dresp_a.data_ok), 64'd0);
    reset_a = 1'b1;
    set_req(1'b0, 1'b0, 64'd0, 64'd0, 8'h00);
    step();
    access(1'b0, 64'h200, 64'h0, 8'h00, 1'b0, rd, lat);
    check_eq("rstop_latency", 64'(lat), 64'd2);
    check_eq("rstop_mem_kept", rd, 64'h0000000000001111);

    // LATENCY=1 back-to-back reads with valid held across
    access(1'b1, 64'h0, 64'h000000000000A0A0, 8'hFF, 1'b0, rd, lat);
    check_eq("b_wr0_latency", 64'(lat), 64'd1);
    access(1'b1, 64'h8, 64'h000000000000B0B0, 8'hFF, 1'b0, rd, lat);
    set_req(1'b1, 1'b1, 64'h0, 64'h0, 8'h00);
    step();
    check_eq("b2b_c1_addr_ok", 64'(dresp_b.addr_ok), 64'd1);
    check_eq("b2b_c1_data_ok", 64'(dresp_b.data_ok), 64'd0);
    step();
    check_eq("b2b_c2_data_ok", 64'(dresp_b.data_ok), 64'd1);
    check_eq("b2b_c2_addr_ok", 64'(dresp_b.addr_ok), 64'd0);
    check_eq("b2b_c2_data", dresp_b.data, 64'h000000000000A0A0);
    set_req(1'b1, 1'b1, 64'h8, 64'h0, 8'h00);
    step();
    check_eq("b2b_c3_addr_ok", 64'(dresp_b.addr_ok), 64'd1);
    check_eq("b2b_c3_data_ok", 64'(dresp_b.data_ok), 64'd0);
    step();
    check_eq("b2b_c4_data_ok", 64'(dresp_b.data_ok), 64'd1);
    check_eq("b2b_c4_data", dresp_b.data, 64'h000000000000B0B0);
    set_req(1'b1, 1'b0, 64'd0, 64'd0, 8'h00);
    step();
    check_eq("b2b_c5_data_ok", 64'(dresp_b.data_ok), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
